pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register for the pipelined DLX datapath, extending the 32-bit enable/load register to arbitrary width. It adds a valid/ready handshake with a two-entry skid buffer, so back-pressure never forms a combinational path from `out_ready` to `in_ready`. A synchronous flush and a synchronous load-override serve branch redirects, and a saturating stall counter supports performance debug. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `BUBBLE_VALUE`, 0: value driven on `out_data` whenever `out_valid`=0 (WIDTH bits).
- `CNT_W`, 16: stall-counter width (≥2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: upstream has a payload.
- `in_ready` output 1: stage accepts a payload this cycle.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes the head this cycle.
- `out_data` output WIDTH: head payload, or `BUBBLE_VALUE` when empty.
- `flush` input 1: discard all held entries at the next edge.
- `load` input 1: replace contents with `load_data` at the next edge.
- `load_data` input WIDTH: payload injected by `load`.
- `occupancy` output 2: number of held entries, 0..2.
- `stall_cnt` output CNT_W: cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- **Storage:** `main` (head) holds the oldest entry and `skid` holds the second. Each has a valid bit. Order is strictly FIFO.
- **Handshake:**
  - `push` = `in_valid` & `in_ready`.
  - `pop` = `out_valid` & `out_ready`.
  - `in_ready` = !`skid_valid` & !`flush` & !`load`. The skid term is registered; `flush`/`load` gate it combinationally.
  - `out_valid` = `main_valid`.
  - `out_data` = `main_valid` ? `main_data` : `BUBBLE_VALUE`.
- **Normal update** (no flush, no load):
  - Empty, push: `main` = `in_data`.
  - One entry, push & pop: `main` = `in_data`.
  - One entry, push only: `skid` = `in_data`.
  - One entry, pop only: empty.
  - Two entries, pop: `main` = `skid`, `skid` invalid. No push is possible because `in_ready`=0.
  - No push and no pop: hold.
- **Priority at each edge:** reset > flush > load > normal update.
- **flush:** both valid bits clear. A pop in the same cycle counts as delivered; the remaining entries are discarded. No push occurs, since `in_ready` is forced to 0.
- **load:** `main` = `load_data`, valid; `skid` invalid. Any held entries are discarded and no push occurs.
- **flush & load in the same cycle:** flush wins and the stage ends empty.
- **occupancy:** equals `main_valid` + `skid_valid`. `skid_valid`=1 implies `main_valid`=1.
- **stall_cnt:**
  - Increments by 1 each cycle with `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by reset; flush and load do not clear it.

## Timing
- **Reset:** while `rst_n`=0 at an edge, the next state is:
  - both valid bits 0;
  - `out_valid`=0, `out_data`=`BUBBLE_VALUE`;
  - `occupancy`=0, `stall_cnt`=0;
  - `in_ready`=1 once `flush`/`load` are low.
- **Inputs during reset:** all other inputs are ignored.
- **Reset mid-transfer:** any held payloads are lost; no partial state survives.
- **Latency:** a payload pushed at edge N is presented on `out_data` with `out_valid`=1 after edge N, i.e. 1 cycle.
- **Throughput:** 1 payload per cycle while `out_ready`=1.
- **Back-pressure:** `in_ready` falls one cycle after the first stalled push, because `skid` fills. It rises one cycle after the pop that drains `skid`.
- **Load/flush effect:** takes effect at the same edge they are sampled. `out_valid` reflects it in the following cycle.
- **Combinational paths:** none from `out_ready` to `in_ready` or `out_data`. The only combinational inputs to `in_ready` are `flush` and `load`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF, then release. Required: `out_valid`=0, `out_data`=`BUBBLE_VALUE`, `occupancy`=0, `stall_cnt`=0, `in_ready`=1. Nothing is captured.
- **Streaming:** push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready`=1. Required: `out_data` shows 0x1, 0x2, 0x3 on the next three cycles, `in_ready` stays 1, `occupancy` ≤1.
- **Back-pressure:**
  - Stimulus: `out_ready`=0; push 0xA then 0xB.
  - Required while stalled: `occupancy`=2 and `in_ready`=0 from the cycle after 0xB. A held 0xC is not accepted.
  - Stimulus: raise `out_ready`.
  - Required: outputs 0xA, 0xB, 0xC in order with no loss or duplication.
  - Required on `stall_cnt`: it equals the number of stalled valid cycles.
- **Flush vs load:**
  - With 2 entries held, assert `flush` and `load` together with `load_data`=0x55. Required: stage empty next cycle and `in_ready`=0 during that cycle.
  - Repeat with `load` only. Required: `out_data`=0x55, `occupancy`=1.
- **Pop during flush:** at `occupancy`=1, assert `out_ready` and `flush` together. Required: the head is delivered once, the stage is empty next cycle, and a concurrent `in_valid` is not accepted.
- **Counter saturation:** with `CNT_W`=2, stall 6 cycles. Required: `stall_cnt` reads 1, 2, 3, 3, 3, 3; then `flush`, and `stall_cnt` still reads 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// Flush/load redirect the stage; a saturating counter tracks stalled-head cycles.
module pipe_stage_reg #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   BUBBLE_VALUE = '0,
    parameter int                 CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             main_valid, main_valid_d;
    logic [WIDTH-1:0] main_data,  main_data_d;
    logic             skid_valid, skid_valid_d;
    logic [WIDTH-1:0] skid_data,  skid_data_d;
    logic             push, pop, stall_inc;

    // in_ready depends only on registered skid state plus flush/load, never on out_ready.
    assign in_ready  = !skid_valid && !flush && !load;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : BUBBLE_VALUE;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign push      = in_valid && in_ready;
    assign pop       = main_valid && out_ready;
    assign stall_inc = main_valid && !out_ready && (stall_cnt != CNT_MAX);

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load) begin
            main_valid_d = 1'b1;
            main_data_d  = load_data;
            skid_valid_d = 1'b0;
        end else if (skid_valid) begin
            // Full: only a pop can happen, skid advances to head.
            if (pop) begin
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid) begin
            if (push && pop) begin
                main_data_d = in_data;
            end else if (push) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VALUE;
            stall_cnt  <= '0;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush/load,
// pop-during-flush, reset mid-transfer and stall-counter saturation.
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB   = 32'hBBBB_0000;
    localparam logic [7:0]  SBUB  = 8'hEE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush, load;
    logic [31:0] in_data, out_data, load_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush, s_load;
    logic [7:0]  s_in_data, s_out_data, s_load_data;
    logic [1:0]  s_occupancy;
    logic [1:0]  s_stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VALUE(BUB), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .load(load), .load_data(load_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .BUBBLE_VALUE(SBUB), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .flush(s_flush), .load(s_load), .load_data(s_load_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        flush = 1'b0; load = 1'b0; load_data = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        s_flush = 1'b0; s_load = 1'b0; s_load_data = '0;

        // Reset with a valid payload presented
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, BUB);
        chk("rst_occ",       {30'b0, occupancy}, 32'd0);
        chk("rst_stall",     {16'b0, stall_cnt}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        tick();
        chk("rst_nocapture", {31'b0, out_valid}, 32'd0);

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            tick();
            chk("stream_data",  out_data, i);
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_rdy",   {31'b0, in_ready}, 32'd1);
            chk("stream_occ",   {30'b0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'b0, out_valid}, 32'd0);
        chk("stream_stall", {16'b0, stall_cnt}, 32'd0);

        // Back-pressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        chk("bp_occ1",  {30'b0, occupancy}, 32'd1);
        chk("bp_rdy1",  {31'b0, in_ready}, 32'd1);
        in_data = 32'hB;
        tick();
        chk("bp_occ2",  {30'b0, occupancy}, 32'd2);
        chk("bp_rdy0",  {31'b0, in_ready}, 32'd0);
        in_data = 32'hC;
        tick();
        chk("bp_hold_occ", {30'b0, occupancy}, 32'd2);
        chk("bp_hold_hd",  out_data, 32'hA);
        tick();
        chk("bp_stall3", {16'b0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        tick();
        chk("bp_out_a_popped", out_data, 32'hB);
        chk("bp_occ_after",    {30'b0, occupancy}, 32'd1);
        chk("bp_rdy_back",     {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_occ_c", {30'b0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty",     {31'b0, out_valid}, 32'd0);
        chk("bp_stall_end", {16'b0, stall_cnt}, 32'd3);

        // Flush and load together: flush wins
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_occ2", {30'b0, occupancy}, 32'd2);
        flush = 1'b1; load = 1'b1; load_data = 32'h55; in_data = 32'h99;
        #1;
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; load = 1'b0; in_valid = 1'b0;
        chk("fl_occ0",   {30'b0, occupancy}, 32'd0);
        chk("fl_bubble", out_data, BUB);
        chk("fl_stall",  {16'b0, stall_cnt}, 32'd5);

        // Load only over two held entries
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0; load = 1'b1;
        #1;
        chk("ld_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        load = 1'b0;
        chk("ld_data", out_data, 32'h55);
        chk("ld_occ",  {30'b0, occupancy}, 32'd1);

        // Pop during flush at occupancy 1
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        #1;
        chk("pf_deliver_v", {31'b0, out_valid}, 32'd1);
        chk("pf_deliver_d", out_data, 32'h55);
        chk("pf_in_ready",  {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("pf_empty", {30'b0, occupancy}, 32'd0);
        tick();
        chk("pf_noaccept", {31'b0, out_valid}, 32'd0);
        chk("pf_stall",    {16'b0, stall_cnt}, 32'd7);

        // Reset mid-transfer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
        tick();
        chk("mr_occ1", {30'b0, occupancy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("mr_occ0",   {30'b0, occupancy}, 32'd0);
        chk("mr_bubble", out_data, BUB);
        chk("mr_stall",  {16'b0, stall_cnt}, 32'd0);

        // Saturating stall counter, CNT_W=2
        s_in_valid = 1'b1; s_in_data = 8'h5A;
        tick();
        s_in_valid = 1'b0;
        chk("sat_start", {30'b0, s_stall_cnt}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("sat_cnt", {30'b0, s_stall_cnt}, (i < 3) ? i : 3);
        end
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        chk("sat_after_flush", {30'b0, s_stall_cnt}, 32'd3);
        chk("sat_occ0",        {30'b0, s_occupancy}, 32'd0);
        chk("sat_bubble",      {24'b0, s_out_data}, {24'b0, SBUB});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
